// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter
//   Shares one multi-cycle multiplier between N_REQ requesters. Each job is
//   taken over a per-requester valid/ready handshake and issued to the
//   multiplier. The arbiter then waits for the result and returns it over a
//   per-requester response handshake.
//
// Build option:
//   MULTIPLIER_ARB_FIXED_PRIO_EN - when defined, the lowest-index active
//   requester always wins and the round-robin pointer is removed. When
//   undefined (default), the search starts at rr_ptr and wraps.
//
// Ports:
//   clk, rst          clock (posedge); asynchronous active-low reset
//   req_vld/req_rdy   per-requester job handshake (req_rdy one-hot or zero)
//   req_a/req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_vld/rsp_rdy   per-requester result handshake (rsp_vld one-hot or zero)
//   rsp_res           product for the requester shown on rsp_vld, else 0
//   busy              high whenever a job is in flight
//   mul_a/mul_b/mul_vld  operands and start strobe to the multiplier
//   mul_res/mul_rdy      product and idle/done flag from the multiplier
module multiplier_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  output logic [N_REQ-1:0]         req_rdy,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         rsp_vld,
  input  logic [N_REQ-1:0]         rsp_rdy,
  output logic [2*WIDTH-1:0]       rsp_res,
  output logic                     busy,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_vld,
  input  logic [2*WIDTH-1:0]       mul_res,
  input  logic                     mul_rdy
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [2*WIDTH-1:0] res_reg, res_next;

  logic [ID_W-1:0]    win;
  logic               win_found;

`ifndef MULTIPLIER_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
`endif

  // Winner selection
  always_comb begin
    win       = '0;
    win_found = 1'b0;
`ifdef MULTIPLIER_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit, i.e. the lowest index, is kept.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_vld[k]) begin
        win       = ID_W'(k);
        win_found = 1'b1;
      end
    end
`else
    // Start at rr_ptr and wrap past N_REQ-1 back to 0; first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_vld[(int'(rr_ptr_reg) + k) % N_REQ]) begin
        win       = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
        win_found = 1'b1;
      end
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    res_next    = res_reg;
`ifndef MULTIPLIER_ARB_FIXED_PRIO_EN
    rr_ptr_next = rr_ptr_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (win_found && mul_rdy) begin
          id_next    = win;
          a_next     = req_a[win*WIDTH +: WIDTH];
          b_next     = req_b[win*WIDTH +: WIDTH];
          state_next = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      // The multiplier must first show it has taken the job before
      // mul_rdy can be trusted as "done".
      WAIT_BUSY: if (!mul_rdy) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (mul_rdy) begin
          res_next   = mul_res;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_rdy[id_reg]) begin
          state_next  = IDLE;
`ifndef MULTIPLIER_ARB_FIXED_PRIO_EN
          rr_ptr_next = (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + ID_W'(1);
`endif
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      id_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
`ifndef MULTIPLIER_ARB_FIXED_PRIO_EN
      rr_ptr_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      id_reg     <= id_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      res_reg    <= res_next;
`ifndef MULTIPLIER_ARB_FIXED_PRIO_EN
      rr_ptr_reg <= rr_ptr_next;
`endif
    end
  end

  // Outputs decode from the state register only, so an asynchronous reset
  // clears them immediately.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign req_rdy[gi] = (state_reg == ISSUE) && (id_reg == ID_W'(gi));
      assign rsp_vld[gi] = (state_reg == RESP)  && (id_reg == ID_W'(gi));
    end
  endgenerate

  logic mul_hold;
  assign mul_hold = (state_reg == ISSUE) || (state_reg == WAIT_BUSY) ||
                    (state_reg == WAIT_DONE);

  assign mul_vld = (state_reg == ISSUE);
  assign mul_a   = mul_hold ? a_reg : '0;
  assign mul_b   = mul_hold ? b_reg : '0;
  assign rsp_res = (state_reg == RESP) ? res_reg : '0;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: behavioural multi-cycle multiplier, directed
// jobs with hand-computed products, scoreboard queues checked by a monitor.
module tb_multiplier_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    rsp_vld;
  logic [N-1:0]    rsp_rdy;
  logic [2*W-1:0]  rsp_res;
  logic            busy;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic            mul_vld;
  logic [2*W-1:0]  mul_res;
  logic            mul_rdy;

  multiplier_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_res(rsp_res), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld),
    .mul_res(mul_res), .mul_rdy(mul_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: drops rdy for LAT cycles after a start strobe.
  logic [W-1:0] pa, pb;
  int           cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_rdy <= 1'b1;
      mul_res <= '0;
      pa      <= '0;
      pb      <= '0;
      cnt     <= 0;
    end else if (mul_vld && mul_rdy) begin
      mul_rdy <= 1'b0;
      mul_res <= '0;
      pa      <= mul_a;
      pb      <= mul_b;
      cnt     <= LAT;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mul_res <= {8'd0, pa} * {8'd0, pb};
        mul_rdy <= 1'b1;
      end
    end
  end

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; } grant_t;
  typedef struct { int id; logic [2*W-1:0] res; } rsp_t;
  grant_t exp_grant_q[$];
  rsp_t   exp_rsp_q[$];

  int  n_vec, n_err;
  int  timeouts;
  bit  final_check;

  // Monitor: owns the counters, samples on the falling edge.
  grant_t         g;
  rsp_t           r;
  bit             prev_hold, handshake, final_done;
  logic [N-1:0]   prev_vld, want_oh;
  logic [2*W-1:0] prev_res;
  initial begin
    n_vec = 0; n_err = 0; prev_hold = 0; final_done = 0;
    prev_vld = '0; prev_res = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_vec++;
        if ({req_rdy, rsp_vld, rsp_res, busy, mul_vld, mul_a, mul_b} != '0) begin
          n_err++;
          $display("FAIL reset_outputs: got req_rdy=%b rsp_vld=%b rsp_res=%h busy=%b mul_vld=%b mul_a=%h mul_b=%h, want all 0",
                   req_rdy, rsp_vld, rsp_res, busy, mul_vld, mul_a, mul_b);
        end
        prev_hold = 0;
      end else begin
        n_vec++;
        if ((rsp_vld == '0 && rsp_res != '0) || (!busy && mul_vld)) begin
          n_err++;
          $display("FAIL idle_outputs: got rsp_vld=%b rsp_res=%h busy=%b mul_vld=%b, want rsp_res=0 without rsp_vld and no mul_vld when idle",
                   rsp_vld, rsp_res, busy, mul_vld);
        end
        if (prev_hold) begin
          n_vec++;
          if (rsp_vld != prev_vld || rsp_res != prev_res || req_rdy != '0 || mul_vld) begin
            n_err++;
            $display("FAIL backpressure: got rsp_vld=%b rsp_res=%h req_rdy=%b mul_vld=%b, want rsp_vld=%b rsp_res=%h req_rdy=0 mul_vld=0",
                     rsp_vld, rsp_res, req_rdy, mul_vld, prev_vld, prev_res);
          end
        end
        if (req_rdy != '0) begin
          n_vec++;
          if (exp_grant_q.size() == 0) begin
            n_err++;
            $display("FAIL grant: got unexpected req_rdy=%b, want none", req_rdy);
          end else begin
            g = exp_grant_q.pop_front();
            want_oh = 4'b0001 << g.id;
            if (req_rdy != want_oh || !mul_vld || mul_a != g.a || mul_b != g.b) begin
              n_err++;
              $display("FAIL grant: got req_rdy=%b mul_vld=%b mul_a=%h mul_b=%h, want req_rdy=%b mul_vld=1 mul_a=%h mul_b=%h",
                       req_rdy, mul_vld, mul_a, mul_b, want_oh, g.a, g.b);
            end else begin
              $display("grant   req%0d a=%h b=%h", g.id, g.a, g.b);
            end
          end
        end
        handshake = (rsp_vld & rsp_rdy) != '0;
        if (handshake) begin
          n_vec++;
          if (exp_rsp_q.size() == 0) begin
            n_err++;
            $display("FAIL response: got unexpected rsp_vld=%b rsp_res=%h, want none", rsp_vld, rsp_res);
          end else begin
            r = exp_rsp_q.pop_front();
            want_oh = 4'b0001 << r.id;
            if (rsp_vld != want_oh || rsp_res != r.res || !busy) begin
              n_err++;
              $display("FAIL response: got rsp_vld=%b rsp_res=%h busy=%b, want rsp_vld=%b rsp_res=%h busy=1",
                       rsp_vld, rsp_res, busy, want_oh, r.res);
            end else begin
              $display("result  req%0d res=%h", r.id, r.res);
            end
          end
        end
        prev_hold = (rsp_vld != '0) && !handshake;
        prev_vld  = rsp_vld;
        prev_res  = rsp_res;
      end
      if (final_check && !final_done) begin
        final_done = 1;
        n_vec++;
        if (exp_grant_q.size() != 0 || exp_rsp_q.size() != 0 || timeouts != 0 || busy) begin
          n_err++;
          $display("FAIL end_of_test: got grants_left=%0d results_left=%0d timeouts=%0d busy=%b, want 0 0 0 0",
                   exp_grant_q.size(), exp_rsp_q.size(), timeouts, busy);
        end
      end
    end
  end

  // Stimulus helpers
  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input bit want_rsp);
    grant_t gg;
    rsp_t   rr;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_vld[id]      = 1'b1;
    gg.id = id; gg.a = a; gg.b = b;
    exp_grant_q.push_back(gg);
    if (want_rsp) begin
      rr.id = id; rr.res = exp;
      exp_rsp_q.push_back(rr);
    end
  endtask

  // One falling edge; a requester drops req_vld once it sees its req_rdy.
  task automatic step();
    @(negedge clk);
    req_vld = req_vld & ~req_rdy;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      step();
      if (!busy && req_vld == '0 && exp_grant_q.size() == 0 && exp_rsp_q.size() == 0)
        done = 1;
    end
    if (!done) begin
      timeouts++;
      $display("FAIL timeout %s: got busy=%b req_vld=%b, want idle with empty queues", name, busy, req_vld);
    end
  endtask

  task automatic wait_rsp_vld(input int id, input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      if (rsp_vld[id]) done = 1;
    end
    if (!done) begin
      timeouts++;
      $display("FAIL timeout %s: got rsp_vld=%b, want bit %0d set", name, rsp_vld, id);
    end
  endtask

  task automatic wait_mul_busy(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      if (!mul_rdy) done = 1;
    end
    if (!done) begin
      timeouts++;
      $display("FAIL timeout %s: got mul_rdy=%b, want 0", name, mul_rdy);
    end
  endtask

  initial begin
    rst = 1'b0; req_vld = '0; rsp_rdy = '1; req_a = '0; req_b = '0;
    timeouts = 0; final_check = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Single job on requester 0
    @(posedge clk); #1;
    set_req(0, 8'h0C, 8'h0D, 16'h009C, 1);
    wait_idle("single");

    // Max operands on requester 2
    @(posedge clk); #1;
    set_req(2, 8'hFF, 8'hFF, 16'hFE01, 1);
    wait_idle("max");

    // All four requesting from reset release
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 8'd1, 8'd2, 16'd2, 1);
    set_req(1, 8'd3, 8'd4, 16'd12, 1);
    set_req(2, 8'd5, 8'd6, 16'd30, 1);
    set_req(3, 8'd7, 8'd8, 16'd56, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle("all4");

    // Back-pressure on requester 1 with requester 0 waiting behind it
    @(posedge clk); #1;
    rsp_rdy = 4'b1101;
    set_req(1, 8'd6, 8'd7, 16'd42, 1);
    wait_rsp_vld(1, "bp_rsp");
    @(posedge clk); #1;
    set_req(0, 8'd2, 8'd9, 16'd18, 1);
    repeat (10) step();
    @(posedge clk); #1;
    rsp_rdy = 4'b1111;
    wait_idle("bp");

    // Reset during WAIT_DONE drops the job
    @(posedge clk); #1;
    set_req(3, 8'd4, 8'd4, 16'd16, 0);
    wait_mul_busy("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) step();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    set_req(0, 8'd3, 8'd5, 16'd15, 1);
    wait_idle("after_rst");

    // Wrap-around: grant 3, then 0 and 3 together -> 0 first
    @(posedge clk); #1;
    set_req(3, 8'd9, 8'd9, 16'd81, 1);
    wait_idle("wrap_a");
    @(posedge clk); #1;
    set_req(0, 8'd10, 8'd11, 16'd110, 1);
    set_req(3, 8'd12, 8'd13, 16'd156, 1);
    wait_idle("wrap_b");

    final_check = 1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle `Multiplier` instance between N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `in_a`/`in_b`/`in_vld` one job at a time.
- Waits for completion via `res_rdy`, then returns the product to the winning requester over a per-requester response handshake.
- Sits between client blocks and the `Multiplier` in the multiplier subsystem top level.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; product width is 2*WIDTH

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- req_vld  in  N_REQ  per-requester job valid
- req_rdy  out  N_REQ  per-requester job accept; one-hot or zero
- req_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- rsp_vld  out  N_REQ  per-requester result valid; one-hot or zero
- rsp_rdy  in  N_REQ  per-requester result accept
- rsp_res  out  2*WIDTH  product for the requester whose rsp_vld is high
- busy  out  1  high whenever state != IDLE
- mul_a  out  WIDTH  to Multiplier in_a
- mul_b  out  WIDTH  to Multiplier in_b
- mul_vld  out  1  to Multiplier in_vld
- mul_res  in  2*WIDTH  from Multiplier res
- mul_rdy  in  1  from Multiplier res_rdy; high = idle/result valid

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; rr_ptr=0; captured id/operands/result=0.
- FSM states: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
- IDLE
  - If any req_vld and mul_rdy=1: pick the winner, latch its req_a/req_b slice and id, go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection: first requester with req_vld=1 searching from rr_ptr upward, wrapping at N_REQ-1 -> 0.
- ISSUE (exactly 1 cycle)
  - mul_vld=1, mul_a/mul_b = latched operands.
  - req_rdy[id]=1; this is the accept handshake.
  - Go to WAIT_BUSY.
- Requester rules:
  - Must hold req_vld and operands stable until req_rdy.
  - Dropping req_vld before accept is illegal, and the arbiter does not check it.
- mul_a/mul_b hold the latched operands from ISSUE through WAIT_DONE. mul_vld=0 in all other states.
- WAIT_BUSY: stay until mul_rdy=0, then go to WAIT_DONE.
- WAIT_DONE: stay until mul_rdy=1. On that cycle capture mul_res into the result register and go to RESP.
- RESP
  - rsp_vld[id]=1, rsp_res=captured result.
  - Hold until rsp_rdy[id]=1. On that cycle go to IDLE and set rr_ptr=(id+1) mod N_REQ.
- Minimum latency: accept to rsp_vld = 3 cycles + multiplier busy time. A new job can be accepted at the earliest 1 cycle after the RESP handshake.
- rsp_rdy of non-selected requesters is ignored. rsp_res is 0 outside RESP.
- Simultaneous requests: exactly one is granted per job. A requester that keeps req_vld high is granted again only after every other active requester has been served (no starvation).
- Full product width: no truncation; rsp_res = mul_res bit-for-bit.
- Reset mid-job: FSM returns to IDLE immediately and the in-flight job is dropped with no response. The multiplier reset is handled at the top level.

Optional Feature:
- Macro: MULTIPLIER_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index requester with req_vld wins; rr_ptr logic is removed.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single job: req_vld[0]=1, a=0x0C, b=0x0D -> req_rdy[0] pulses once; rsp_vld[0] later with rsp_res=0x009C; busy high for the whole job.
- Max operands: requester 2 sends a=0xFF, b=0xFF -> rsp_res=0xFE01; rsp_vld only on bit 2.
- All 4 requesters hold req_vld from reset release with products 1*2, 3*4, 5*6, 7*8 -> grants in order 0,1,2,3 and results 2, 12, 30, 56. Under MULTIPLIER_ARB_FIXED_PRIO_EN with requester 0 re-requesting each time, requester 0 is always granted.
- Back-pressure: hold rsp_rdy[1]=0 for 10 cycles -> rsp_vld[1] and rsp_res stay stable, no new req_rdy, mul_vld=0; accept occurs 1 cycle after rsp_rdy[1]=1.
- Reset mid-job: deassert rst during WAIT_DONE -> all outputs go to 0 asynchronously and no rsp_vld appears; after release, a new job a=3, b=5 returns 15.
- Wrap-around: grant requester 3, then have requesters 0 and 3 both request -> requester 0 is granted next.
